// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and defaults for the fully connected layer
package fc_pkg;

   typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} fc_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_N_IN   = 9;
   localparam int DEF_N_OUT  = 4;

   localparam int W_RESET = 1;
   localparam int B_RESET = 0;

endpackage

// File: rtl/fc_act_sat.sv
// rtl/fc_act_sat.sv - optional ReLU followed by saturation from ACC_W to DATA_W
module fc_act_sat
   import fc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = 2*DEF_DATA_W + $clog2(DEF_N_IN+1)
)(
   input  logic signed [ACC_W-1:0]  acc,
   input  logic                     relu_en,
   output logic signed [DATA_W-1:0] y,
   output logic                     ovf
);

   logic signed [ACC_W-1:0] v;

   always_comb begin
      v   = (relu_en && acc[ACC_W-1]) ? '0 : acc;
      ovf = 1'b0;
      y   = v[DATA_W-1:0];
      // Value fits only if every bit above the output sign bit matches it.
      if (v[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){v[ACC_W-1]}}) begin
         ovf = 1'b1;
         y   = v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/fc_layer_mo.sv
// rtl/fc_layer_mo.sv - multi-output fully connected layer on one shared MAC
module fc_layer_mo
   import fc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_IN   = DEF_N_IN,
   parameter int N_OUT  = DEF_N_OUT,
   parameter int ACC_W  = 2*DATA_W + $clog2(N_IN+1),
   parameter int ADDR_W = $clog2(N_OUT*(N_IN+1))
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     relu_en,
   input  logic [N_IN*DATA_W-1:0]   fc_input,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [N_OUT*DATA_W-1:0]  fc_out,
   output logic                     sat_flag
);

   localparam int N_W    = N_OUT*N_IN;
   localparam int N_COEF = N_OUT*(N_IN+1);
   localparam int I_W    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int O_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int EXT    = ACC_W - 2*DATA_W;

   fc_state_t state, state_nx;

   logic signed [DATA_W-1:0]   coef [N_COEF];
   logic [N_IN*DATA_W-1:0]     in_lat;
   logic                       relu_lat;
   logic [I_W-1:0]             i_cnt;
   logic [O_W-1:0]             o_cnt;
   logic signed [ACC_W-1:0]    acc;
   logic                       pend_vld;
   logic [ADDR_W-1:0]          pend_addr;
   logic signed [DATA_W-1:0]   pend_data;
   logic signed [DATA_W-1:0]   x_cur, w_cur, b_first, b_next, act_y;
   logic signed [2*DATA_W-1:0] prod;
   logic                       act_ovf, last_i, last_o, wr_ok;

   assign x_cur   = in_lat[32'(i_cnt)*DATA_W +: DATA_W];
   assign w_cur   = coef[ADDR_W'(o_cnt)*ADDR_W'(N_IN) + ADDR_W'(i_cnt)];
   assign b_first = coef[ADDR_W'(N_W)];
   assign b_next  = coef[ADDR_W'(N_W) + ADDR_W'(o_cnt) + ADDR_W'(1)];
   assign prod    = x_cur * w_cur;
   assign last_i  = (i_cnt == I_W'(N_IN-1));
   assign last_o  = (o_cnt == O_W'(N_OUT-1));
   assign wr_ok   = wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(N_COEF));

   fc_act_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_act (
      .acc     (acc),
      .relu_en (relu_lat),
      .y       (act_y),
      .ovf     (act_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = MAC;
         MAC: begin
            busy = 1'b1;
            if (last_i) state_nx = ACT;
         end
         ACT: begin
            busy     = 1'b1;
            state_nx = last_o ? DONE : MAC;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_COEF; k++)
            coef[k] <= (k < N_W) ? DATA_W'(W_RESET) : DATA_W'(B_RESET);
         in_lat    <= '0;
         relu_lat  <= 1'b0;
         i_cnt     <= '0;
         o_cnt     <= '0;
         acc       <= '0;
         pend_vld  <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         fc_out    <= '0;
         sat_flag  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  in_lat    <= fc_input;
                  relu_lat  <= relu_en;
                  sat_flag  <= 1'b0;
                  acc       <= {{(ACC_W-DATA_W){b_first[DATA_W-1]}}, b_first};
                  i_cnt     <= '0;
                  o_cnt     <= '0;
                  // A write arriving with start is parked so this run sees the old value.
                  pend_vld  <= wr_ok;
                  pend_addr <= wr_addr;
                  pend_data <= wr_data;
               end else if (wr_ok) begin
                  coef[wr_addr] <= wr_data;
               end
            end
            MAC: begin
               acc   <= acc + {{EXT{prod[2*DATA_W-1]}}, prod};
               i_cnt <= last_i ? '0 : i_cnt + 1'b1;
            end
            ACT: begin
               fc_out[32'(o_cnt)*DATA_W +: DATA_W] <= act_y;
               if (act_ovf) sat_flag <= 1'b1;
               if (!last_o) begin
                  o_cnt <= o_cnt + 1'b1;
                  acc   <= {{(ACC_W-DATA_W){b_next[DATA_W-1]}}, b_next};
               end
            end
            DONE: begin
               if (pend_vld) coef[pend_addr] <= pend_data;
               pend_vld <= 1'b0;
               if (wr_ok) coef[wr_addr] <= wr_data;
            end
            default: ;
         endcase
      end
   end

endmodule
